// File: rtl/serial_arith_pkg.sv
// Shared encodings and sizing helpers for the digit-serial add/subtract datapath.
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StComp = ST_COMP,
    StDone = ST_DONE
  } state_e;

  function automatic int unsigned ndig_f(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 0 : width / digit;
  endfunction

  // One extra bit keeps the counter from collapsing to zero width when NDIG is 1.
  function automatic int unsigned cnt_w_f(input int unsigned ndig);
    return $clog2(ndig) + 1;
  endfunction

endpackage

// File: rtl/serial_addsub_digit_if.sv
// Operand/result channels of the digit-serial adder/subtractor.
interface serial_addsub_digit_if #(
  parameter int unsigned WIDTH = 128
);
  logic [WIDTH-1:0] x;
  logic             op_sub;
  logic             data_x_vld;
  logic             data_x_rdy;
  logic [WIDTH-1:0] y;
  logic             data_y_vld;
  logic             data_y_rdy;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             d_out_vld;
  logic             d_out_rdy;
  logic             busy;

  modport master (
    output x, op_sub, data_x_vld, y, data_y_vld, d_out_rdy,
    input  data_x_rdy, data_y_rdy, sum, cout, ovf, d_out_vld, busy
  );

  modport slave (
    input  x, op_sub, data_x_vld, y, data_y_vld, d_out_rdy,
    output data_x_rdy, data_y_rdy, sum, cout, ovf, d_out_vld, busy
  );
endinterface

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module serial_digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial X+/-Y: captures both operands, processes DIGIT bits per cycle LSB first,
// then holds sum/cout/ovf on a valid/ready output channel.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIGIT = 4
) (
  input logic                  clk,
  input logic                  asyn_reset,
  serial_addsub_digit_if.slave bus
);

  localparam int unsigned NDIG  = ndig_f(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_w_f(NDIG);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub_digit: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic             hx_q, hx_d, hy_q, hy_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic             x_fire, y_fire, sub_sel;
  logic [WIDTH-1:0] y_src;
  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_cmsb;

  serial_digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a    (x_q[DIGIT-1:0]),
    .b    (y_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout),
    .c_msb(dig_cmsb)
  );

  assign bus.data_x_rdy = (state_q == StIdle) && !hx_q && !asyn_reset;
  assign bus.data_y_rdy = (state_q == StIdle) && !hy_q && !asyn_reset;
  assign x_fire         = bus.data_x_vld && bus.data_x_rdy;
  assign y_fire         = bus.data_y_vld && bus.data_y_rdy;

  // Mode and Y may arrive this edge or already be held; the inversion uses whichever is current.
  assign sub_sel = x_fire ? bus.op_sub : op_q;
  assign y_src   = y_fire ? bus.y : y_q;

  always_comb begin
    state_d = state_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (x_fire) begin
          x_d  = bus.x;
          op_d = bus.op_sub;
          hx_d = 1'b1;
        end
        if (y_fire) begin
          y_d  = bus.y;
          hy_d = 1'b1;
        end
        if ((hx_q || x_fire) && (hy_q || y_fire)) begin
          y_d     = sub_sel ? ~y_src : y_src;
          carry_d = sub_sel;
          cnt_d   = '0;
          state_d = StComp;
        end
      end
      StComp: begin
        x_d                    = x_q >> DIGIT;
        y_d                    = y_q >> DIGIT;
        res_d                  = res_q >> DIGIT;
        res_d[WIDTH-1 -: DIGIT] = dig_s;
        carry_d                = dig_cout;
        cnt_d                  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          hx_d    = 1'b0;
          hy_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.d_out_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q <= StIdle;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sum       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.d_out_vld = (state_q == StDone);
  assign bus.busy      = (state_q == StComp) || (state_q == StDone);

endmodule
